// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment score display.
// Segment codes are active-low, bit6=g .. bit0=a.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } seg_state_t;

    localparam logic [6:0] SEG_DARK = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h18
    };

    // Shift-add-3 correction applied to a BCD nibble before each shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// One-digit BCD to active-low segment decoder.
// Ports: bcd (digit), dark (force 7F), dash (force 3F, below dark), seg.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dark,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DARK;
        if (dark) begin
            seg = SEG_DARK;
        end else if (dash) begin
            seg = SEG_DASH;
        end else if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/seg_score_display.sv
// Multi-digit score display: sequential binary-to-BCD (shift-add-3)
// behind a load/ready handshake, driving NUM_DIGITS active-low digits.
// Ports: clock, reset_L (sync, active-low), bin_in/load/ready,
//   blank_mask, lz_suppress, blink, seg_out, overflow, busy.
// Optional macro SEG_BLINK_EN adds a BLINK_DIV-cycle blink phase.
module seg_score_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 14,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    input  logic                    load,
    output logic                    ready,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    input  logic                    blink,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam int SW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    seg_state_t state;
    seg_state_t state_next;

    logic [BIN_WIDTH-1:0] sr;
    logic [SW-1:0]        scratch;
    logic [SW-1:0]        adj;
    logic                 carry;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        disp;
    logic                 disp_valid;
    logic                 blink_off;

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        busy  = (state != IDLE);
    end

    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj[4*i +: 4] = dd_adjust(scratch[4*i +: 4]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            sr         <= '0;
            scratch    <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            disp       <= '0;
            disp_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        sr      <= bin_in;
                        scratch <= '0;
                        carry   <= 1'b0;
                        cnt     <= CW'(BIN_WIDTH);
                    end
                end
                SHIFT: begin
                    // Bit leaving the top nibble means the value
                    // no longer fits in NUM_DIGITS decimal digits.
                    scratch <= {adj[SW-2:0], sr[BIN_WIDTH-1]};
                    carry   <= carry | adj[SW-1];
                    sr      <= sr << 1;
                    cnt     <= cnt - CW'(1);
                end
                COMMIT: begin
                    disp       <= scratch;
                    overflow   <= carry;
                    disp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BKW-1:0] bcnt;
    logic           phase;

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BKW'(BLINK_DIV - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + BKW'(1);
        end
    end

    assign blink_off = blink & phase;
`else
    logic unused_blink;
    assign unused_blink = blink ^ (BLINK_DIV == 0);
    assign blink_off    = 1'b0;
`endif

    // lead[i]: digits i and above are all zero.
    logic [NUM_DIGITS:0]   lead;
    logic [NUM_DIGITS-1:0] lz_dark;

    always_comb begin
        lead             = '0;
        lead[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead[i] = lead[i+1] && (disp[4*i +: 4] == 4'd0);
        end
        lz_dark = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_dark[i] = lz_suppress && lead[i];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic dark;
        assign dark = !disp_valid || blink_off || blank_mask[g]
                   || (!overflow && lz_dark[g]);
        seg_digit_decode u_dec (
            .bcd  (disp[4*g +: 4]),
            .dark (dark),
            .dash (overflow),
            .seg  (seg_out[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_seg_score_display.sv
// Self-checking bench for seg_score_display (scoreboard style).
// Build with +define+SEG_BLINK_EN to also exercise blinking.
module tb_seg_score_display;

    localparam int ND   = 4;
    localparam int BW   = 14;
    localparam int BDIV = 4;

    logic            clock;
    logic            reset_L;
    logic [BW-1:0]   bin_in;
    logic            load;
    logic            ready;
    logic [ND-1:0]   blank_mask;
    logic            lz_suppress;
    logic            blink;
    logic [7*ND-1:0] seg_out;
    logic            overflow;
    logic            busy;

    seg_score_display #(
        .NUM_DIGITS (ND),
        .BIN_WIDTH  (BW),
        .BLINK_DIV  (BDIV)
    ) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .bin_in      (bin_in),
        .load        (load),
        .ready       (ready),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .blink       (blink),
        .seg_out     (seg_out),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int            v;
        bit            lz;
        logic [ND-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    localparam logic [7*ND-1:0] ALL_DARK = {ND{7'h7F}};

`ifdef SEG_BLINK_EN
    int mc;
    bit mp;
    always @(posedge clock) begin
        if (!reset_L) begin
            mc <= 0;
            mp <= 1'b0;
        end else if (mc == BDIV - 1) begin
            mc <= 0;
            mp <= ~mp;
        end else begin
            mc <= mc + 1;
        end
    end
`endif

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h18;
        endcase
    endfunction

    function automatic logic [7*ND-1:0] exp_seg(input int v,
                                               input bit lz,
                                               input logic [ND-1:0] mask,
                                               input bit boff);
        logic [7*ND-1:0] r;
        int p;
        bit ov;
        r  = ALL_DARK;
        ov = (v >= 10000);
        p  = 1;
        if (!boff) begin
            for (int i = 0; i < ND; i++) begin
                if (mask[i])
                    r[7*i +: 7] = 7'h7F;
                else if (ov)
                    r[7*i +: 7] = 7'h3F;
                else if (lz && i > 0 && v < p)
                    r[7*i +: 7] = 7'h7F;
                else
                    r[7*i +: 7] = code((v / p) % 10);
                p = p * 10;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input int v);
        exp_t e;
        bin_in = BW'(v);
        load   = 1'b1;
        tick();
        load   = 1'b0;
        e.v    = v;
        e.lz   = lz_suppress;
        e.mask = blank_mask;
        sb.push_back(e);
    endtask

    task automatic finish_load(input string tag, input int skipped);
        int   low;
        exp_t e;
        low = 0;
        while (!ready && low < 100) begin
            low++;
            tick();
        end
        chk({tag, "_lat"}, 64'(low), 64'(BW + 1 - skipped));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            chk({tag, "_seg"}, 64'(seg_out),
                64'(exp_seg(e.v, e.lz, e.mask, 1'b0)));
            chk({tag, "_ovf"}, 64'(overflow), 64'(e.v >= 10000));
            chk({tag, "_rdy"}, 64'(ready), 64'(1));
        end
    endtask

    task automatic run(input string tag, input int v);
        start_load(v);
        finish_load(tag, 0);
    endtask

    initial begin
        reset_L     = 1'b0;
        bin_in      = '0;
        load        = 1'b0;
        blank_mask  = '0;
        lz_suppress = 1'b0;
        blink       = 1'b0;
        tick();
        tick();
        chk("rst_seg", 64'(seg_out), 64'(ALL_DARK));
        chk("rst_rdy", 64'(ready), 64'(1));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset_L = 1'b1;
        tick();
        chk("idle_seg", 64'(seg_out), 64'(ALL_DARK));

        run("b1234", 1234);

        lz_suppress = 1'b1;
        run("lz7", 7);
        lz_suppress = 1'b0;
        #1;
        chk("lz7_off", 64'(seg_out), 64'(exp_seg(7, 1'b0, '0, 1'b0)));

        lz_suppress = 1'b1;
        run("zero", 0);
        run("lz120", 120);
        lz_suppress = 1'b0;

        run("ovf", 10000);
        run("max", 9999);
        run("ovf_big", 16383);
        run("mid", 1005);

        start_load(42);
        tick();
        tick();
        bin_in = BW'(99);
        load   = 1'b1;
        tick();
        load   = 1'b0;
        finish_load("busy", 3);

        blank_mask = 4'b0001;
        run("mask", 1234);
        blank_mask = 4'b1010;
        lz_suppress = 1'b1;
        run("mask_lz", 56);
        blank_mask = '0;
        lz_suppress = 1'b0;

        start_load(5000);
        repeat (4) tick();
        reset_L = 1'b0;
        tick();
        chk("rstmid_rdy", 64'(ready), 64'(1));
        chk("rstmid_seg", 64'(seg_out), 64'(ALL_DARK));
        chk("rstmid_ovf", 64'(overflow), 64'(0));
        sb.delete();
        reset_L = 1'b1;
        tick();
        run("after_rst", 5);

`ifdef SEG_BLINK_EN
        blank_mask = 4'b0001;
        run("bl_val", 1234);
        blink = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("blink", 64'(seg_out),
                64'(exp_seg(1234, 1'b0, 4'b0001, mp)));
        end
        blink = 1'b0;
        #1;
        chk("blink_off", 64'(seg_out),
            64'(exp_seg(1234, 1'b0, 4'b0001, 1'b0)));
        blank_mask = '0;
`else
        blink = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("noblink", 64'(seg_out),
                64'(exp_seg(5, 1'b0, '0, 1'b0)));
        end
        blink = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
